// File: rtl/tsip_pkg.sv
// Shared constants, FSM encoding and packet byte offsets for the TSIP timing parser.
package tsip_pkg;

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;

  // De-stuffed data byte offsets, index 0 being the subcode
  localparam int OFS_FLAGS   = 9;
  localparam int OFS_SEC     = 10;
  localparam int OFS_MIN     = 11;
  localparam int OFS_HOUR    = 12;
  localparam int OFS_DAY     = 13;
  localparam int OFS_MONTH   = 14;
  localparam int OFS_YEAR_HI = 15;
  localparam int OFS_YEAR_LO = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_DLE,
    ST_DATA,
    ST_DATA_DLE,
    ST_SKIP,
    ST_SKIP_DLE
  } tsip_state_e;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
    logic [7:0]  flags;
  } tsip_time_t;

endpackage

// File: rtl/tsip_destuffer.sv
// TSIP framing FSM: strips DLE stuffing and reports frame start (matching ID),
// data bytes, frame end and DLE framing errors as single-cycle strobes.
module tsip_destuffer
  import tsip_pkg::*;
#(
  parameter logic [7:0] PKT_ID = 8'h8F
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_dv_i,
  input  logic [7:0]  rx_byte_i,
  output logic        byte_dv_o,
  output logic [7:0]  byte_o,
  output logic        sof_o,
  output logic [7:0]  sof_id_o,
  output logic        eof_o,
  output logic        frm_err_o,
  output tsip_state_e state_o
);

  tsip_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Strobe contract: each output strobe is valid only in the cycle rx_dv_i is
  // high; there is no back-pressure, every accepted byte is consumed at once.
  always_comb begin
    state_d   = state_q;
    byte_dv_o = 1'b0;
    byte_o    = rx_byte_i;
    sof_o     = 1'b0;
    sof_id_o  = rx_byte_i;
    eof_o     = 1'b0;
    frm_err_o = 1'b0;
    if (rx_dv_i) begin
      unique case (state_q)
        ST_IDLE: if (rx_byte_i == DLE) state_d = ST_GOT_DLE;
        ST_GOT_DLE: begin
          if (rx_byte_i == PKT_ID) begin
            state_d = ST_DATA;
            sof_o   = 1'b1;
          end else if (rx_byte_i == DLE || rx_byte_i == ETX) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_DATA: begin
          if (rx_byte_i == DLE) state_d = ST_DATA_DLE;
          else                  byte_dv_o = 1'b1;
        end
        ST_DATA_DLE: begin
          if (rx_byte_i == DLE) begin
            byte_dv_o = 1'b1;
            state_d   = ST_DATA;
          end else if (rx_byte_i == ETX) begin
            eof_o   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Unstuffed DLE + B: abandon this frame, B is the next frame's ID
            frm_err_o = 1'b1;
            sof_o     = (rx_byte_i == PKT_ID);
            state_d   = (rx_byte_i == PKT_ID) ? ST_DATA : ST_SKIP;
          end
        end
        ST_SKIP: if (rx_byte_i == DLE) state_d = ST_SKIP_DLE;
        ST_SKIP_DLE: begin
          if (rx_byte_i == DLE)      state_d = ST_SKIP;
          else if (rx_byte_i == ETX) state_d = ST_IDLE;
          else begin
            sof_o   = (rx_byte_i == PKT_ID);
            state_d = (rx_byte_i == PKT_ID) ? ST_DATA : ST_SKIP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/tsip_timing_parser.sv
// Extracts UTC time from TSIP Primary Timing Packets (0x8F/0xAB).
// Optional rejected-frame counter enabled by defining TSIP_ERR_CNT_EN.
module tsip_timing_parser
  import tsip_pkg::*;
#(
  parameter logic [7:0] PKT_ID   = 8'h8F,
  parameter logic [7:0] SUBCODE  = 8'hAB,
  parameter int         DATA_LEN = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_thunder_packet_dv,
  output logic [15:0] o_thunder_year,
  output logic [7:0]  o_thunder_month,
  output logic [7:0]  o_thunder_day,
  output logic [7:0]  o_thunder_hour,
  output logic [7:0]  o_thunder_minutes,
  output logic [7:0]  o_thunder_seconds,
  output logic [7:0]  o_timing_flags
`ifdef TSIP_ERR_CNT_EN
  ,
  output logic [15:0] o_frame_err_cnt
`endif
);

  localparam logic [4:0] LEN     = 5'(DATA_LEN);
  localparam logic [4:0] CNT_MAX = 5'(DATA_LEN + 1);
  localparam logic [4:0] OFS_LO  = 5'(OFS_FLAGS);
  localparam logic [4:0] OFS_HI  = 5'(OFS_YEAR_LO);

  logic        byte_dv, sof, eof, frm_err;
  logic [7:0]  byte_val, sof_id;
  tsip_state_e dstf_state;

  tsip_destuffer #(.PKT_ID(PKT_ID)) u_destuffer (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .rx_dv_i   (i_rx_dv),
    .rx_byte_i (i_rx_byte),
    .byte_dv_o (byte_dv),
    .byte_o    (byte_val),
    .sof_o     (sof),
    .sof_id_o  (sof_id),
    .eof_o     (eof),
    .frm_err_o (frm_err),
    .state_o   (dstf_state)
  );

  logic [4:0] cnt_q, cnt_d;
  logic       bad_q, bad_d;
  logic [7:0] shd_q [8];
  logic       shd_we;
  logic [2:0] shd_idx;
  logic       sof_acc, store_en, commit;
  tsip_time_t time_q;
  logic       dv_q;

  assign sof_acc  = sof && (sof_id == PKT_ID);
  assign store_en = byte_dv && (dstf_state == ST_DATA || dstf_state == ST_DATA_DLE);
  assign commit   = eof && (cnt_q == LEN) && !bad_q;

  always_comb begin
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    shd_we  = 1'b0;
    shd_idx = '0;
    if (sof_acc) begin
      cnt_d = '0;
      bad_d = 1'b0;
    end else if (store_en) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
      if (cnt_q >= LEN) begin
        bad_d = 1'b1;
      end else begin
        if (cnt_q == 5'd0 && byte_val != SUBCODE) bad_d = 1'b1;
        if (cnt_q >= OFS_LO && cnt_q <= OFS_HI) begin
          shd_we  = 1'b1;
          shd_idx = 3'(cnt_q - OFS_LO);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      bad_q  <= 1'b0;
      time_q <= '0;
      dv_q   <= 1'b0;
      for (int i = 0; i < 8; i++) shd_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      bad_q <= bad_d;
      dv_q  <= commit;
      if (shd_we) shd_q[shd_idx] <= byte_val;
      // Shadow slot order follows the byte offsets: flags first, year low last
      if (commit) begin
        time_q.flags   <= shd_q[0];
        time_q.seconds <= shd_q[1];
        time_q.minutes <= shd_q[2];
        time_q.hour    <= shd_q[3];
        time_q.day     <= shd_q[4];
        time_q.month   <= shd_q[5];
        time_q.year    <= {shd_q[6], shd_q[7]};
      end
    end
  end

  assign o_thunder_packet_dv = dv_q;
  assign o_thunder_year      = time_q.year;
  assign o_thunder_month     = time_q.month;
  assign o_thunder_day       = time_q.day;
  assign o_thunder_hour      = time_q.hour;
  assign o_thunder_minutes   = time_q.minutes;
  assign o_thunder_seconds   = time_q.seconds;
  assign o_timing_flags      = time_q.flags;

`ifdef TSIP_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        frame_rej;

  // A frame ends exactly once: either at ETX or at a DLE framing error
  assign frame_rej = (eof && !commit) || frm_err;

  always_ff @(posedge i_clk) begin
    if (i_rst)                                   err_cnt_q <= '0;
    else if (frame_rej && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign o_frame_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tsip_timing_parser.sv
// Directed bench for tsip_timing_parser: frames are driven byte by byte and
// expected commits are queued for a monitor that checks fields and latency.
module tb_tsip_timing_parser;
  import tsip_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        pkt_dv;
  logic [15:0] year;
  logic [7:0]  month, day, hour, minutes, seconds, flags;
`ifdef TSIP_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  tsip_timing_parser dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_rx_dv             (rx_dv),
    .i_rx_byte           (rx_byte),
    .o_thunder_packet_dv (pkt_dv),
    .o_thunder_year      (year),
    .o_thunder_month     (month),
    .o_thunder_day       (day),
    .o_thunder_hour      (hour),
    .o_thunder_minutes   (minutes),
    .o_thunder_seconds   (seconds),
    .o_timing_flags      (flags)
`ifdef TSIP_ERR_CNT_EN
    ,
    .o_frame_err_cnt     (err_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [63:0] last_val = '0;
  logic [7:0]  pay_q[$];
  int          gap = 1;

  wire [63:0] dut_fields = {year, month, day, hour, minutes, seconds, flags};

  function automatic logic [63:0] pack(input logic [15:0] y, input logic [7:0] mo,
                                       input logic [7:0] d, input logic [7:0] h,
                                       input logic [7:0] mi, input logic [7:0] s,
                                       input logic [7:0] f);
    return {y, mo, d, h, mi, s, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    repeat (gap) begin
      @(negedge clk);
      rx_dv = 1'b0;
    end
  endtask

  task automatic send_payload(input int from, input int to);
    for (int i = from; i < to; i++) begin
      send_byte(pay_q[i]);
      if (pay_q[i] == DLE) send_byte(DLE);
    end
  endtask

  task automatic send_etx(input bit expect_commit, input logic [63:0] val);
    send_byte(DLE);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = ETX;
    if (expect_commit) begin
      exp_q.push_back(val);
      exp_cyc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] id, input bit expect_commit, input logic [63:0] val);
    send_byte(DLE);
    send_byte(id);
    send_payload(0, pay_q.size());
    send_etx(expect_commit, val);
  endtask

  task automatic build(input logic [7:0] sub, input logic [63:0] f);
    pay_q.delete();
    pay_q.push_back(sub);
    for (int i = 0; i < 8; i++) pay_q.push_back(8'(8'h21 + i));
    pay_q.push_back(f[7:0]);
    pay_q.push_back(f[15:8]);
    pay_q.push_back(f[23:16]);
    pay_q.push_back(f[31:24]);
    pay_q.push_back(f[39:32]);
    pay_q.push_back(f[47:40]);
    pay_q.push_back(f[63:56]);
    pay_q.push_back(f[55:48]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && pkt_dv) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_dv: strobe at cycle %0d, none expected", cyc);
      end else begin
        check("commit_fields", dut_fields, exp_q.pop_front());
        check("commit_latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] v1, v2, v3, v4, v6;

  initial begin
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = '0;
    v1 = pack(16'h07E8, 8'h07, 8'h19, 8'h0C, 8'h0F, 8'h1E, 8'h00);
    v2 = pack(16'h07E8, 8'h07, 8'h19, 8'h0C, 8'h0F, 8'h10, 8'h5A);
    v3 = pack(16'h0123, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    v4 = pack(16'h07E9, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    v6 = pack(16'h07EA, 8'h0C, 8'h1F, 8'h17, 8'h3B, 8'h3C, 8'h81);
    repeat (3) @(negedge clk);
    check("reset_fields", dut_fields, '0);
    check("reset_dv", 64'(pkt_dv), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic valid frame
    build(8'hAB, v1);
    send_frame(8'h8F, 1'b1, v1);
    last_val = v1;

    // stuffed seconds byte, bytes back to back
    gap = 0;
    build(8'hAB, v2);
    send_frame(8'h8F, 1'b1, v2);
    gap = 1;
    last_val = v2;

    // short then long frame
    build(8'hAB, v3);
    void'(pay_q.pop_back());
    send_frame(8'h8F, 1'b0, '0);
    build(8'hAB, v3);
    pay_q.push_back(8'h55);
    send_frame(8'h8F, 1'b0, '0);
    check("held_after_len", dut_fields, last_val);
`ifdef TSIP_ERR_CNT_EN
    check("err_cnt_len", 64'(err_cnt), 64'(2));
`endif

    // wrong subcode, then foreign packet ID with stuffed DLE inside
    build(8'hAC, v3);
    send_frame(8'h8F, 1'b0, '0);
    build(8'hAB, v2);
    send_frame(8'h47, 1'b0, '0);
    check("held_after_id", dut_fields, last_val);
`ifdef TSIP_ERR_CNT_EN
    check("err_cnt_id", 64'(err_cnt), 64'(3));
`endif

    // reset mid-frame, tail of the frame must not commit
    build(8'hAB, v4);
    send_byte(DLE);
    send_byte(8'h8F);
    send_payload(0, 8);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_reset_fields", dut_fields, '0);
`ifdef TSIP_ERR_CNT_EN
    check("mid_reset_err", 64'(err_cnt), 64'(0));
`endif
    rst = 1'b0;
    last_val = '0;
    send_payload(8, pay_q.size());
    send_etx(1'b0, '0);
    check("held_after_tail", dut_fields, last_val);
    send_frame(8'h8F, 1'b1, v4);
    last_val = v4;

    // DLE + ID mid-frame restarts parsing
    build(8'hAB, v3);
    send_byte(DLE);
    send_byte(8'h8F);
    send_payload(0, 5);
    build(8'hAB, v6);
    send_frame(8'h8F, 1'b1, v6);
    last_val = v6;
`ifdef TSIP_ERR_CNT_EN
    check("err_cnt_restart", 64'(err_cnt), 64'(1));
`endif

    repeat (5) @(negedge clk);
    check("held_final", dut_fields, last_val);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
